// File: rtl/mm_conv_sequencer_pkg.sv
// Shared encodings for the multiplier-array sequencer: precision codes, mode codes,
// FSM states and lane-mask helpers.
package mm_conv_sequencer_pkg;

    localparam logic [1:0] CONV_2 = 2'b01;
    localparam logic [1:0] CONV_4 = 2'b10;
    localparam logic [1:0] CONV_8 = 2'b11;

    // Mode code is {convtypeD, convtypeW}
    localparam logic [3:0] M8x8 = {CONV_8, CONV_8};
    localparam logic [3:0] M8x4 = {CONV_8, CONV_4};
    localparam logic [3:0] M8x2 = {CONV_8, CONV_2};
    localparam logic [3:0] M4x4 = {CONV_4, CONV_4};
    localparam logic [3:0] M4x2 = {CONV_4, CONV_2};
    localparam logic [3:0] M2x2 = {CONV_2, CONV_2};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] cw);
        case (cw)
            CONV_8:  lane_mask = 4'b0001;
            CONV_4:  lane_mask = 4'b0011;
            CONV_2:  lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic mode_legal(input logic [1:0] cd, input logic [1:0] cw);
        case ({cd, cw})
            M8x8, M8x4, M8x2, M4x4, M4x2, M2x2: mode_legal = 1'b1;
            default:                            mode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mm_conv_sequencer_if.sv
// Command, operand, multiplier and result signals of the sequencer.
interface mm_conv_sequencer_if #(
    parameter int LEN_W = 10,
    parameter int ACC_W = 24
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [LEN_W-1:0]   cmd_len;
    logic [1:0]         cmd_convtypeD;
    logic [1:0]         cmd_convtypeW;
    logic               op_valid;
    logic               op_ready;
    logic [7:0]         op_d;
    logic [31:0]        op_w;
    logic [7:0]         mm_d;
    logic [7:0]         mm_w1;
    logic [7:0]         mm_w2;
    logic [7:0]         mm_w3;
    logic [7:0]         mm_w4;
    logic [1:0]         mm_convtypeD;
    logic [1:0]         mm_convtypeW;
    logic [63:0]        mm_mul;
    logic               res_valid;
    logic               res_ready;
    logic [4*ACC_W-1:0] res_acc;
    logic [3:0]         res_ovf;
    logic               res_err;
    logic               busy;

    modport slave (
        input  cmd_valid, cmd_len, cmd_convtypeD, cmd_convtypeW,
        input  op_valid, op_d, op_w, mm_mul, res_ready,
        output cmd_ready, op_ready, mm_d, mm_w1, mm_w2, mm_w3, mm_w4,
        output mm_convtypeD, mm_convtypeW, res_valid, res_acc, res_ovf, res_err, busy
    );

    modport master (
        output cmd_valid, cmd_len, cmd_convtypeD, cmd_convtypeW,
        output op_valid, op_d, op_w, mm_mul, res_ready,
        input  cmd_ready, op_ready, mm_d, mm_w1, mm_w2, mm_w3, mm_w4,
        input  mm_convtypeD, mm_convtypeW, res_valid, res_acc, res_ovf, res_err, busy
    );
endinterface

// File: rtl/mm_conv_sequencer_lane.sv
// One saturating signed accumulator lane with synchronous clear and sticky overflow.
module mm_lane_acc #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [15:0]      prod_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [ACC_W:0]   sum;

    // One guard bit: overflow shows up as disagreement between the top two bits
    assign sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-16){prod_i[15]}}, prod_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (en_i) begin
            if (sum[ACC_W] != sum[ACC_W-1]) begin
                acc_q <= sum[ACC_W] ? ACC_MIN : ACC_MAX;
                ovf_q <= 1'b1;
            end else begin
                acc_q <= sum[ACC_W-1:0];
            end
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/mm_conv_sequencer.sv
// Dot-product job sequencer: feeds one multi-precision multiplier and accumulates lanes.
//   state   | meaning
//   IDLE    | waiting for a job command
//   CHECK   | one cycle mode/length validation
//   LOAD    | accepting operand beats
//   DRAIN   | two cycles letting the product/accumulate pipe empty
//   OUT     | result presented until handshake
module mm_conv_sequencer
    import mm_conv_sequencer_pkg::*;
#(
    parameter int LEN_W = 10,
    parameter int ACC_W = 24
) (
    input logic                clk,
    input logic                rst_n,
    mm_conv_sequencer_if.slave bus
);
    state_t           state_q, state_d;
    logic [1:0]       cvd_q, cvw_q;
    logic [LEN_W-1:0] rem_q;
    logic             drn_q, err_q, v1_q, v2_q;
    logic [7:0]       d_q;
    logic [31:0]      w_q;
    logic [63:0]      prod_q;
    logic             cmd_acc, op_rdy, beat;
    logic [3:0]       mask, ovf;
    logic [ACC_W-1:0] acc [4];

    assign cmd_acc = (state_q == S_IDLE) && bus.cmd_valid;
    assign op_rdy  = (state_q == S_LOAD) && (rem_q != '0);
    assign beat    = op_rdy && bus.op_valid;
    assign mask    = lane_mask(cvw_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.cmd_valid) state_d = S_CHECK;
            S_CHECK: state_d = (!mode_legal(cvd_q, cvw_q) || rem_q == '0) ? S_OUT : S_LOAD;
            S_LOAD:  if (rem_q == '0) state_d = S_DRAIN;
            S_DRAIN: if (!drn_q) state_d = S_OUT;
            S_OUT:   if (bus.res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cvd_q  <= '0;
            cvw_q  <= '0;
            rem_q  <= '0;
            drn_q  <= 1'b0;
            err_q  <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            d_q    <= '0;
            w_q    <= '0;
            prod_q <= '0;
        end else begin
            if (cmd_acc) begin
                cvd_q <= bus.cmd_convtypeD;
                cvw_q <= bus.cmd_convtypeW;
                rem_q <= bus.cmd_len;
                err_q <= 1'b0;
            end else if (beat) begin
                rem_q <= rem_q - 1'b1;
            end
            if (state_q == S_CHECK) err_q <= !mode_legal(cvd_q, cvw_q);
            // Drain down-counter is reloaded throughout LOAD, so DRAIN always lasts two cycles
            if (state_q == S_LOAD)       drn_q <= 1'b1;
            else if (state_q == S_DRAIN) drn_q <= 1'b0;
            if (beat) begin
                d_q <= bus.op_d;
                w_q <= bus.op_w;
            end
            v1_q <= beat;
            v2_q <= v1_q;
            if (v1_q) prod_q <= bus.mm_mul;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        mm_lane_acc #(.ACC_W(ACC_W)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (cmd_acc),
            .en_i   (v2_q && mask[i]),
            .prod_i (prod_q[16*i +: 16]),
            .acc_o  (acc[i]),
            .ovf_o  (ovf[i])
        );
        assign bus.res_acc[i*ACC_W +: ACC_W] = acc[i];
    end

    assign bus.cmd_ready    = (state_q == S_IDLE);
    assign bus.op_ready     = op_rdy;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.res_valid    = (state_q == S_OUT);
    assign bus.res_ovf      = ovf;
    assign bus.res_err      = err_q;
    assign bus.mm_d         = d_q;
    assign bus.mm_w1        = w_q[7:0];
    assign bus.mm_w2        = w_q[15:8];
    assign bus.mm_w3        = w_q[23:16];
    assign bus.mm_w4        = w_q[31:24];
    assign bus.mm_convtypeD = cvd_q;
    assign bus.mm_convtypeW = cvw_q;
endmodule

// File: tb/tb_mm_conv_sequencer.sv
// Directed bench for mm_conv_sequencer with ACC_W=17 so saturation is reachable.
module tb_mm_conv_sequencer;
    localparam int LEN_W = 10;
    localparam int ACC_W = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    mm_conv_sequencer_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

    mm_conv_sequencer #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lane(input int i);
        logic signed [ACC_W-1:0] v;
        v = bus.res_acc[i*ACC_W +: ACC_W];
        return int'(v);
    endfunction

    task automatic start_job(input logic [LEN_W-1:0] len, input logic [1:0] cd, input logic [1:0] cw);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len = len;
        bus.cmd_convtypeD = cd;
        bus.cmd_convtypeW = cw;
        while (!bus.cmd_ready && n < 20) begin tick(); n++; end
        checks++;
        if (!bus.cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%0b required 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic [31:0] w, output int acc_cyc);
        int n = 0;
        bus.op_valid = 1'b1;
        bus.op_d = d;
        bus.op_w = w;
        while (!bus.op_ready && n < 20) begin tick(); n++; end
        checks++;
        if (!bus.op_ready) begin
            errors++;
            $display("FAIL op_accept_timeout: op_ready=%0b required 1", bus.op_ready);
        end
        tick();
        acc_cyc = cyc;
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_res(output int rcyc);
        int n = 0;
        while (!bus.res_valid && n < 20) begin tick(); n++; end
        checks++;
        if (!bus.res_valid) begin
            errors++;
            $display("FAIL res_valid_timeout: res_valid=%0b required 1", bus.res_valid);
        end
        rcyc = cyc;
    endtask

    task automatic ack_res();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic check_lanes(input string tag, input int e0, input int e1, input int e2, input int e3,
                               input logic [3:0] eovf, input logic eerr);
        int exp [4];
        exp = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lane(i) !== exp[i]) begin
                errors++;
                $display("FAIL %s lane%0d: got %0d required %0d", tag, i, lane(i), exp[i]);
            end
        end
        checks++;
        if (bus.res_ovf !== eovf || bus.res_err !== eerr) begin
            errors++;
            $display("FAIL %s ovf/err: got %b/%b required %b/%b", tag, bus.res_ovf, bus.res_err, eovf, eerr);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.op_ready !== 1'b0 || bus.res_valid !== 1'b0 ||
            bus.res_acc !== '0 || bus.res_ovf !== 4'b0 || bus.res_err !== 1'b0 || bus.mm_d !== 8'h0 ||
            bus.mm_w1 !== 8'h0 || bus.mm_convtypeD !== 2'b0 || bus.mm_convtypeW !== 2'b0) begin
            errors++;
            $display("FAIL reset_state: cmd_ready=%b busy=%b res_valid=%b acc=%h required 1,0,0,0",
                     bus.cmd_ready, bus.busy, bus.res_valid, bus.res_acc);
        end
    endtask

    task automatic test_8x8();
        int a, r;
        bus.mm_mul = {16'h1234, 16'h5678, 16'h0FFF, 16'hFDA8};
        start_job(10'd2, 2'b11, 2'b11);
        checks++;
        if (bus.mm_convtypeD !== 2'b11 || bus.mm_convtypeW !== 2'b11 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL 8x8_mode_latch: got D=%b W=%b busy=%b required 11 11 1",
                     bus.mm_convtypeD, bus.mm_convtypeW, bus.busy);
        end
        send_beat(8'd200, 32'h112233FD, a);
        checks++;
        if (bus.mm_d !== 8'd200 || bus.mm_w1 !== 8'hFD || bus.mm_w2 !== 8'h33 || bus.mm_w4 !== 8'h11) begin
            errors++;
            $display("FAIL 8x8_mm_regs: got d=%h w1=%h w2=%h w4=%h required c8 fd 33 11",
                     bus.mm_d, bus.mm_w1, bus.mm_w2, bus.mm_w4);
        end
        send_beat(8'd200, 32'h112233FD, a);
        wait_res(r);
        checks++;
        if (r - a !== 3) begin
            errors++;
            $display("FAIL 8x8_latency: got %0d required 3", r - a);
        end
        check_lanes("8x8", -1200, 0, 0, 0, 4'b0000, 1'b0);
        ack_res();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL 8x8_return_idle: cmd_ready=%b res_valid=%b required 1 0", bus.cmd_ready, bus.res_valid);
        end
    endtask

    task automatic test_4x4();
        int a, r;
        bus.mm_mul = {16'h0100, 16'h0200, 16'hFFF9, 16'd50};
        start_job(10'd3, 2'b10, 2'b10);
        for (int k = 0; k < 3; k++) send_beat(8'h5A, 32'h01020304, a);
        wait_res(r);
        check_lanes("4x4", 150, -21, 0, 0, 4'b0000, 1'b0);
        ack_res();
    endtask

    task automatic test_len_zero();
        int r;
        bus.op_valid = 1'b1;
        start_job(10'd0, 2'b11, 2'b11);
        wait_res(r);
        checks++;
        if (bus.op_ready !== 1'b0) begin
            errors++;
            $display("FAIL len0_op_ready: got %b required 0", bus.op_ready);
        end
        check_lanes("len0", 0, 0, 0, 0, 4'b0000, 1'b0);
        bus.op_valid = 1'b0;
        ack_res();
    endtask

    task automatic test_2x2_gaps();
        int a, r, first;
        bus.mm_mul = {16'hFC18, 16'd7, 16'hFFFD, 16'd100};
        start_job(10'd4, 2'b01, 2'b01);
        tick();
        first = cyc;
        send_beat(8'h01, 32'h0, a);
        tick();
        send_beat(8'h02, 32'h0, a);
        send_beat(8'h03, 32'h0, a);
        tick();
        send_beat(8'h04, 32'h0, a);
        wait_res(r);
        checks++;
        if (r - first !== 9 || r - a !== 3) begin
            errors++;
            $display("FAIL 2x2_cycles: got total=%0d lat=%0d required 9 3", r - first, r - a);
        end
        check_lanes("2x2", 400, -12, 28, -4000, 4'b0000, 1'b0);
        ack_res();
    endtask

    task automatic test_saturation();
        int a, r;
        bus.mm_mul = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        start_job(10'd3, 2'b11, 2'b11);
        for (int k = 0; k < 3; k++) send_beat(8'hFF, 32'h7F7F7F7F, a);
        wait_res(r);
        check_lanes("sat_pos", 65535, 0, 0, 0, 4'b0001, 1'b0);
        ack_res();
        bus.mm_mul = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
        start_job(10'd3, 2'b01, 2'b01);
        for (int k = 0; k < 3; k++) send_beat(8'hFF, 32'h80808080, a);
        wait_res(r);
        check_lanes("sat_neg", -65536, -65536, -65536, -65536, 4'b1111, 1'b0);
        ack_res();
        bus.mm_mul = {16'd9, 16'd9, 16'd6, 16'd5};
        start_job(10'd1, 2'b11, 2'b10);
        send_beat(8'h01, 32'h01010101, a);
        wait_res(r);
        check_lanes("ovf_clear", 5, 6, 0, 0, 4'b0000, 1'b0);
        ack_res();
    endtask

    task automatic test_illegal();
        int r;
        int seen = 0;
        bus.op_valid = 1'b1;
        start_job(10'd3, 2'b01, 2'b11);
        for (int k = 0; k < 6 && !bus.res_valid; k++) begin
            if (bus.op_ready) seen++;
            tick();
        end
        wait_res(r);
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL illegal_op_ready: got %0d ready cycles required 0", seen);
        end
        check_lanes("illegal", 0, 0, 0, 0, 4'b0000, 1'b1);
        bus.op_valid = 1'b0;
        ack_res();
    endtask

    task automatic test_stall();
        int a, r;
        bus.mm_mul = {16'h0, 16'h0, 16'h0, 16'hFFFF};
        start_job(10'd1, 2'b11, 2'b11);
        send_beat(8'h01, 32'hFF, a);
        wait_res(r);
        bus.cmd_valid = 1'b1;
        bus.cmd_len = 10'd5;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (bus.res_valid !== 1'b1 || lane(0) !== -1 || bus.res_ovf !== 4'b0 || bus.res_err !== 1'b0 ||
                bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b lane0=%0d cmd_ready=%b required 1 -1 0",
                         k, bus.res_valid, lane(0), bus.cmd_ready);
            end
        end
        bus.cmd_valid = 1'b0;
        ack_res();
        checks++;
        if (lane(0) !== -1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_after_ack: lane0=%0d busy=%b required -1 0", lane(0), bus.busy);
        end
    endtask

    task automatic test_reset_mid_load();
        int a, r;
        bus.mm_mul = {16'h0, 16'h0, 16'h0, 16'd3};
        start_job(10'd5, 2'b11, 2'b11);
        send_beat(8'h11, 32'hAABBCCDD, a);
        send_beat(8'h22, 32'hAABBCCDD, a);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_acc !== '0 ||
            bus.mm_d !== 8'h0 || bus.mm_w4 !== 8'h0 || bus.mm_convtypeD !== 2'b0 || bus.res_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load: busy=%b mm_d=%h acc=%h required 0 00 0", bus.busy, bus.mm_d, bus.res_acc);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0", bus.cmd_ready, bus.busy);
        end
        start_job(10'd1, 2'b11, 2'b11);
        send_beat(8'h01, 32'h1, a);
        wait_res(r);
        check_lanes("post_reset", 3, 0, 0, 0, 4'b0000, 1'b0);
        ack_res();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len = '0;
        bus.cmd_convtypeD = 2'b00;
        bus.cmd_convtypeW = 2'b00;
        bus.op_valid = 1'b0;
        bus.op_d = '0;
        bus.op_w = '0;
        bus.mm_mul = '0;
        bus.res_ready = 1'b0;
        #12 rst_n = 1'b1;
        tick();
        test_reset();
        test_8x8();
        test_4x4();
        test_len_zero();
        test_2x2_gaps();
        test_saturation();
        test_illegal();
        test_stall();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
